nibble_serial_add_ctrl: RTL
===========================

// Module: nibble_serial_add_ctrl
//
// PURPOSE
// - Sequences one shared binary_adder_4_bit instance to add WIDTH-bit operands one nibble per cycle.
// - Nibbles are processed LSB first, with a registered carry between nibbles.
// - Sits between a requesting datapath and the 4-bit adder, trading latency for area.
// - Uses a start/ready/done handshake with operand capture at start.
//
// PARAMETERS
// - WIDTH  16  Operand/result width in bits. Must be a multiple of 4 and >= 4.
//   - Localparam NIBBLES = WIDTH/4.
//
// PORTS
// - clk       in   1      Rising-edge clock.
// - rst_n     in   1      Synchronous reset, active-low.
// - start     in   1      Request to begin an add. Accepted only when ready=1.
// - a         in   WIDTH  Operand A. Captured on accept.
// - b         in   WIDTH  Operand B. Captured on accept.
// - carryin   in   1      Carry into nibble 0. Captured on accept.
// - ready     out  1      1 when in IDLE and able to accept start.
// - busy      out  1      1 during RUN.
// - done      out  1      One-cycle pulse: sum and carryout are final.
// - sum       out  WIDTH  Result register.
// - carryout  out  1      Carry out of the top nibble.
//
// BEHAVIOUR
// - Reset (rst_n=0 at posedge):
//   - State becomes IDLE; nibble index = 0; carry register = 0.
//   - Outputs: sum=0, carryout=0, done=0, busy=0, ready=1.
//   - Reset overrides all other inputs and aborts any operation in flight; the partial result is discarded.
// - FSM has three states:
//   - IDLE: ready=1. If start=1, capture a, b, carryin; set idx=0; clear sum to 0; go to RUN.
//   - RUN: busy=1. The adder gets a[4*idx+:4], b[4*idx+:4] and the carry register.
//     - At the clock edge: sum[4*idx+:4] <= adder sum; carry register <= adder carryout; idx++.
//     - When idx == NIBBLES-1: also load carryout and go to DONE.
//   - DONE: done=1 for exactly this cycle; ready=0; then unconditionally go to IDLE.
// - Timing:
//   - Start accepted at edge 0. RUN occupies NIBBLES cycles. done is high in cycle NIBBLES+1.
//   - Earliest next accept is at the edge that ends the DONE cycle + 1, giving a throughput of 1 op per NIBBLES+2 cycles.
// - start while ready=0 (RUN or DONE) is ignored; there is no queuing.
//   - a, b and carryin may change freely after accept.
// - sum updates nibble-by-nibble during RUN, so intermediate values are visible.
//   - sum and carryout hold their final values after done until the next accepted start.
// - Arithmetic is modulo 2^WIDTH; carryout is bit WIDTH of a+b+carryin.
// - WIDTH=4: a single RUN cycle, done at cycle 2.
//
// CONFIGURATION
// - Macro ADD_SUB_EN:
//   - Defined: adds input port sub (1 bit), captured on accept.
//     - sub=1: operand B nibbles are inverted before the adder and the nibble-0 carry is forced to 1, so sum = a - b mod 2^WIDTH and carryin is ignored.
//     - carryout=1 means no borrow (a >= b).
//     - sub=0: identical to the plain add.
//   - Undefined: no sub port; add only.
//
// TESTING
// - WIDTH=16: start, a=0x1234, b=0x0F0F, carryin=0 -> busy for 4 cycles; done at cycle 5; sum=0x2143, carryout=0.
// - Full ripple: a=0xFFFF, b=0x0001, carryin=0 -> sum=0x0000, carryout=1.
//   - Also a=0xFFFF, b=0x0000, carryin=1 -> same result.
// - start held high throughout with changing operands -> only the first operands are used; next accept occurs one cycle after done.
// - rst_n=0 at the 2nd RUN cycle -> next cycle state=IDLE, ready=1, sum=0, carryout=0, no done pulse.
// - Back-to-back: two ops (0x0001+0x0002, then 0x8000+0x8000) -> sums 0x0003/cout 0, then 0x0000/cout 1; done pulses 6 cycles apart.
// - ADD_SUB_EN, sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, carryout=0. a=0x0007, b=0x0005 -> sum=0x0002, carryout=1.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit adder: one shared 4-bit adder stepped LSB nibble first.
// Optional macro ADD_SUB_EN adds a 'sub' input for two's-complement subtraction.

module binary_adder_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
`ifdef ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             sub_s;
    logic [3:0]       nib_a_s, nib_b_s, nib_sum_s;
    logic             nib_cout_s;
    logic [IDX_W+1:0] shamt_s;
    logic             last_s;

`ifdef ADD_SUB_EN
    assign sub_s = sub;
`else
    assign sub_s = 1'b0;
`endif

    assign shamt_s = {idx_q, 2'b00};
    assign last_s  = (idx_q == IDX_W'(NIBBLES - 1));
    assign nib_a_s = 4'(a_q >> shamt_s);
    assign nib_b_s = 4'(b_q >> shamt_s);

    binary_adder_4_bit u_adder (
        .a    (nib_a_s),
        .b    (nib_b_s),
        .cin  (carry_q),
        .sum  (nib_sum_s),
        .cout (nib_cout_s)
    );

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN; else state_d = S_IDLE;
            S_RUN:   if (last_s) state_d = S_DONE; else state_d = S_RUN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values; subtraction is folded into operand capture
    always_comb begin
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    a_d     = a;
                    b_d     = sub_s ? ~b : b;
                    carry_d = sub_s ? 1'b1 : carryin;
                    sum_d   = '0;
                end else begin
                    idx_d = idx_q;
                end
            end
            S_RUN: begin
                sum_d   = (sum_q & ~(WIDTH'(4'hF) << shamt_s))
                        | (WIDTH'(nib_sum_s) << shamt_s);
                carry_d = nib_cout_s;
                idx_d   = idx_q + IDX_W'(1);
                if (last_s) begin
                    cout_d = nib_cout_s;
                end else begin
                    cout_d = cout_q;
                end
            end
            default: begin
                idx_d = idx_q;
            end
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            S_IDLE:  ready = 1'b1;
            S_RUN:   busy  = 1'b1;
            S_DONE:  done  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign sum      = sum_q;
    assign carryout = cout_q;

endmodule
